logicnet_input_packer: RTL and testbench
========================================

# logicnet_input_packer

Upstream feeder for the LogicNet layer-0 neuron array. Accepts raw feature samples one per beat over a valid/ready stream. Quantises each sample to `IN_BITS` by saturating right shift. Packs `NUM_FEATURES` codes into one wide input vector, which is presented to layer 0 over a valid/ready output with one vector of buffering, so the next vector can fill while the current one waits.

## Interface
Parameters:
- `NUM_FEATURES`, default 32: features per vector (≥2).
- `IN_BITS`, default 2: quantised code width per feature (layer-0 input precision).
- `RAW_WIDTH`, default 8: unsigned raw sample width.
- `SHIFT`, default 6: right-shift applied before saturation (0 ≤ `SHIFT` < `RAW_WIDTH`).

Ports:
- `clk` in 1: the only clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: raw sample valid.
- `s_ready` out 1: block can accept a sample.
- `s_data` in `RAW_WIDTH`: raw unsigned sample.
- `s_last` in 1: marks the final sample of a vector.
- `m_valid` out 1: packed vector valid.
- `m_ready` in 1: layer 0 accepts the vector.
- `m_data` out `NUM_FEATURES*IN_BITS`: packed vector; feature i occupies bits `[i*IN_BITS +: IN_BITS]`, and the first sample received is i=0.
- `err_len` out 1: one-cycle pulse on a framing error.

## Operation
- Quantisation: `code = min(s_data >> SHIFT, 2^IN_BITS - 1)`, unsigned, computed on the accepted beat only.
- Fill buffer plus feature counter `cnt` (0..NUM_FEATURES-1). An accepted beat (`s_valid & s_ready`) writes `code` to slot `cnt` and increments `cnt`.
- FSM states:
  - FILL: `s_ready`=1. Stay in FILL on a beat that is not final.
  - On the final beat (`cnt`=NUM_FEATURES-1):
    - If the output register is empty, or is being consumed this cycle (`m_valid & m_ready`), copy the fill buffer into `m_data`, set `m_valid`, set `cnt`=0 and stay in FILL.
    - Otherwise go to HOLD.
  - HOLD: `s_ready`=0, and the full fill buffer is kept. When the output register frees (`m_ready` with `m_valid`, or `m_valid`=0), copy the fill buffer to the output on that same edge, set `m_valid`=1, clear `cnt` and return to FILL.
- Output register:
  - `m_valid` and `m_data` are held stable while `m_valid & !m_ready`.
  - `m_valid` clears on a handshake unless a new vector loads on the same edge.
- Framing:
  - `s_last` on a beat with `cnt` < NUM_FEATURES-1: drop the partial vector, `cnt`=0, pulse `err_len`, no output.
  - Final beat without `s_last`: vector is still emitted; pulse `err_len`.
  - `s_last` on the final beat: normal, no error.
- Unused fill slots are never exposed; stale contents are overwritten before emission.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `err_len`=0, `cnt`=0, state FILL.
  - `s_ready`=0 while `rst` is high; `s_ready`=1 from the first cycle after `rst` deasserts.
- Latency: `m_valid` rises on the edge that accepts the final beat, so it is visible the next cycle.
- Throughput: with `m_ready` held high and `s_valid` continuous, one vector per NUM_FEATURES cycles with no bubbles.
- `err_len` is registered and asserts the cycle after the offending beat, for exactly 1 cycle.
- `s_ready` is a function of state only. It does not combinationally depend on `m_ready` (no input-to-output combinational path).
- Reset mid-vector or in HOLD discards the partial vector and the pending output. No `m_valid` is produced from pre-reset data.

## Test plan
All cases use `NUM_FEATURES`=4, `IN_BITS`=2, `RAW_WIDTH`=8, `SHIFT`=6 unless stated.
- Basic pack: samples 0x00, 0x40, 0x80, 0xC0 with `s_last` on the 4th, `m_ready`=1 → `m_valid` 1 cycle later, `m_data`=0xE4, `err_len`=0.
- Saturation (`SHIFT`=5): samples 0xFF, 0x20, 0x5F, 0x00 → codes 3, 1, 2, 0 → `m_data`=0x27.
- Backpressure: `m_ready`=0; send vector A (0xE4) then vector B (0x1B) → A held stable, `s_ready` falls after B's 4th beat (HOLD). Raise `m_ready` for 1 cycle → A handshakes, B appears the next cycle, `s_ready` returns to 1.
- Early `s_last` on the 2nd beat → `err_len` 1-cycle pulse, no `m_valid`. The next 4 beats 0xC0 ×4 → `m_data`=0xFF.
- Missing `s_last` on the 4th beat → vector emitted and `err_len` pulses in the same cycle as `m_valid`.
- Assert `rst` after 2 beats and while in HOLD → `m_valid`=0 and `cnt`=0 after reset. A fresh 4-beat vector emits correctly.

Source files
------------

// File: rtl/logicnet_input_packer.sv
// Raw feature sample quantiser and packer for the LogicNet layer-0 input.
// Fills one vector while a second, completed vector waits on the output.
module logicnet_input_packer #(
   parameter int NUM_FEATURES = 32,
   parameter int IN_BITS      = 2,
   parameter int RAW_WIDTH    = 8,
   parameter int SHIFT        = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [RAW_WIDTH-1:0]            s_data,
   input  logic                            s_last,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
   output logic                            err_len
);

   localparam int CW = $clog2(NUM_FEATURES);
   localparam int VW = NUM_FEATURES * IN_BITS;

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   localparam logic [RAW_WIDTH-1:0] MAXC = RAW_WIDTH'((1 << IN_BITS) - 1);
   localparam logic [CW-1:0]        LAST = CW'(NUM_FEATURES - 1);

   logic [0:0]           state;
   logic [CW-1:0]        cnt;
   logic [VW-1:0]        fill;
   logic [VW-1:0]        fill_next;
   logic [RAW_WIDTH-1:0] shifted;
   logic [IN_BITS-1:0]   code;
   logic                 accept;
   logic                 final_beat;
   logic                 out_free;
   logic                 load;

   // Ready depends only on state, never on the output handshake
   assign s_ready    = !rst && (state == FILL);
   assign accept     = s_valid && s_ready;
   assign final_beat = (cnt == LAST);
   assign out_free   = !m_valid || m_ready;

   // Output loads on a completing beat or when a held vector can drain
   assign load = out_free &&
                 ((accept && final_beat) || (state == HOLD));

   // Saturating quantiser
   always_comb begin
      shifted = s_data >> SHIFT;
      if (shifted > MAXC) begin
         code = MAXC[IN_BITS-1:0];
      end else begin
         code = shifted[IN_BITS-1:0];
      end
   end

   // Fill buffer view including the beat accepted this cycle
   always_comb begin
      fill_next = fill;
      if (accept) begin
         fill_next[cnt*IN_BITS +: IN_BITS] = code;
      end
   end

   // Fill buffer, counter, framing and FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FILL;
         cnt     <= '0;
         fill    <= '0;
         err_len <= 1'b0;
      end else begin
         fill    <= fill_next;
         err_len <= accept && (s_last != final_beat);
         unique case (state)
            FILL: begin
               if (accept) begin
                  if (final_beat) begin
                     if (load) begin
                        cnt <= '0;
                     end else begin
                        state <= HOLD;
                     end
                  end else if (s_last) begin
                     cnt <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (load) begin
                  cnt   <= '0;
                  state <= FILL;
               end
            end
            default: begin
               state <= FILL;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Output register, stable under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= fill_next;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Directed bench for logicnet_input_packer.
// Main instance uses SHIFT=6, a second instance uses SHIFT=5.
module tb_logicnet_input_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_last;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       err_len;

   logic       s2_valid;
   logic       s2_ready;
   logic [7:0] s2_data;
   logic       s2_last;
   logic       m2_valid;
   logic       m2_ready;
   logic [7:0] m2_data;
   logic       err2_len;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logicnet_input_packer #(
      .NUM_FEATURES(4), .IN_BITS(2), .RAW_WIDTH(8), .SHIFT(6)
   ) u_dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .err_len(err_len)
   );

   logicnet_input_packer #(
      .NUM_FEATURES(4), .IN_BITS(2), .RAW_WIDTH(8), .SHIFT(5)
   ) u_sat (
      .clk(clk), .rst(rst),
      .s_valid(s2_valid), .s_ready(s2_ready),
      .s_data(s2_data), .s_last(s2_last),
      .m_valid(m2_valid), .m_ready(m2_ready),
      .m_data(m2_data), .err_len(err2_len)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic beat2(input logic [7:0] d, input logic last);
      s2_valid = 1'b1;
      s2_data  = d;
      s2_last  = last;
      step();
      s2_valid = 1'b0;
      s2_last  = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      m_ready  = 1'b0;
      s2_valid = 1'b0;
      s2_data  = '0;
      s2_last  = 1'b0;
      m2_ready = 1'b1;

      // Reset state
      step();
      step();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'h00);
      chk("rst_err_len", 32'(err_len), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      rst = 1'b0;
      step();
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      chk("post_rst_m_valid", 32'(m_valid), 32'd0);

      // Basic pack
      m_ready = 1'b1;
      beat(8'h00, 1'b0);
      beat(8'h40, 1'b0);
      beat(8'h80, 1'b0);
      chk("basic_no_early_valid", 32'(m_valid), 32'd0);
      beat(8'hC0, 1'b1);
      chk("basic_m_valid", 32'(m_valid), 32'd1);
      chk("basic_m_data", 32'(m_data), 32'hE4);
      chk("basic_err_len", 32'(err_len), 32'd0);
      step();
      chk("basic_valid_drop", 32'(m_valid), 32'd0);

      // Saturation on the SHIFT=5 instance
      beat2(8'hFF, 1'b0);
      beat2(8'h20, 1'b0);
      beat2(8'h5F, 1'b0);
      beat2(8'h00, 1'b1);
      chk("sat_m_valid", 32'(m2_valid), 32'd1);
      chk("sat_m_data", 32'(m2_data), 32'h27);
      chk("sat_err_len", 32'(err2_len), 32'd0);

      // Back-to-back vectors with m_ready high
      beat(8'hC0, 1'b0);
      beat(8'h80, 1'b0);
      beat(8'h40, 1'b0);
      beat(8'h00, 1'b1);
      chk("thr_a_data", 32'(m_data), 32'h1B);
      chk("thr_a_ready", 32'(s_ready), 32'd1);
      beat(8'hFF, 1'b0);
      beat(8'h00, 1'b0);
      beat(8'h00, 1'b0);
      beat(8'h40, 1'b1);
      chk("thr_b_valid", 32'(m_valid), 32'd1);
      chk("thr_b_data", 32'(m_data), 32'h43);
      step();

      // Backpressure: A held, B goes to HOLD
      m_ready = 1'b0;
      beat(8'h00, 1'b0);
      beat(8'h40, 1'b0);
      beat(8'h80, 1'b0);
      beat(8'hC0, 1'b1);
      chk("bp_a_valid", 32'(m_valid), 32'd1);
      chk("bp_a_data", 32'(m_data), 32'hE4);
      beat(8'hC0, 1'b0);
      beat(8'h80, 1'b0);
      beat(8'h40, 1'b0);
      chk("bp_fill_ready", 32'(s_ready), 32'd1);
      chk("bp_a_stable", 32'(m_data), 32'hE4);
      beat(8'h00, 1'b1);
      chk("bp_hold_ready", 32'(s_ready), 32'd0);
      chk("bp_hold_valid", 32'(m_valid), 32'd1);
      chk("bp_hold_data", 32'(m_data), 32'hE4);
      step();
      chk("bp_hold2_ready", 32'(s_ready), 32'd0);
      chk("bp_hold2_data", 32'(m_data), 32'hE4);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("bp_b_valid", 32'(m_valid), 32'd1);
      chk("bp_b_data", 32'(m_data), 32'h1B);
      chk("bp_b_ready", 32'(s_ready), 32'd1);
      step();
      chk("bp_b_stable", 32'(m_data), 32'h1B);
      m_ready = 1'b1;
      step();
      chk("bp_b_drain", 32'(m_valid), 32'd0);

      // Early s_last
      beat(8'h40, 1'b0);
      beat(8'h40, 1'b1);
      chk("early_err", 32'(err_len), 32'd1);
      chk("early_no_valid", 32'(m_valid), 32'd0);
      step();
      chk("early_err_pulse", 32'(err_len), 32'd0);
      chk("early_no_valid2", 32'(m_valid), 32'd0);
      beat(8'hC0, 1'b0);
      beat(8'hC0, 1'b0);
      beat(8'hC0, 1'b0);
      beat(8'hC0, 1'b1);
      chk("early_next_valid", 32'(m_valid), 32'd1);
      chk("early_next_data", 32'(m_data), 32'hFF);
      chk("early_next_err", 32'(err_len), 32'd0);
      step();

      // Missing s_last
      beat(8'h00, 1'b0);
      beat(8'h00, 1'b0);
      beat(8'h00, 1'b0);
      beat(8'h40, 1'b0);
      chk("miss_valid", 32'(m_valid), 32'd1);
      chk("miss_data", 32'(m_data), 32'h40);
      chk("miss_err", 32'(err_len), 32'd1);
      step();
      chk("miss_err_pulse", 32'(err_len), 32'd0);

      // Reset mid-vector
      beat(8'hC0, 1'b0);
      beat(8'hC0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(m_valid), 32'd0);
      step();
      m_ready = 1'b0;
      beat(8'h00, 1'b0);
      beat(8'h40, 1'b0);
      beat(8'h80, 1'b0);
      beat(8'hC0, 1'b1);
      chk("rst_mid_cnt_data", 32'(m_data), 32'hE4);
      beat(8'hC0, 1'b0);
      beat(8'hC0, 1'b0);
      beat(8'hC0, 1'b0);
      beat(8'hC0, 1'b1);
      chk("rst_hold_ready", 32'(s_ready), 32'd0);

      // Reset in HOLD
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_hold_valid", 32'(m_valid), 32'd0);
      chk("rst_hold_data", 32'(m_data), 32'h00);
      step();
      chk("rst_hold_no_valid", 32'(m_valid), 32'd0);
      chk("rst_hold_s_ready", 32'(s_ready), 32'd1);
      m_ready = 1'b1;
      beat(8'h40, 1'b0);
      beat(8'h40, 1'b0);
      beat(8'h40, 1'b0);
      beat(8'h40, 1'b1);
      chk("fresh_valid", 32'(m_valid), 32'd1);
      chk("fresh_data", 32'(m_data), 32'h55);
      chk("fresh_err", 32'(err_len), 32'd0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
